// File: rtl/rv_pipeline_ctrl.sv
// Stall/kill sequencer for the uRV pipeline: turns X/W-stage hazard, branch, multi-cycle
// and memory-wait events into fetch/decode/execute stall and kill controls.
module rv_pipeline_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned MC_TIMEOUT   = 64,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             x_valid_i,
    input  logic             x_load_hazard_i,
    input  logic             x_branch_taken_i,
    input  logic             x_mc_start_i,
    input  logic             x_mc_done_i,
    input  logic             w_stall_req_i,
    output logic             f_stall_o,
    output logic             d_stall_o,
    output logic             d_kill_o,
    output logic             x_stall_o,
    output logic             x_kill_o,
    output logic             mc_busy_o,
    output logic             mc_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {StRun, StHaz, StFlush, StMcWait} state_e;

    localparam logic [1:0] FlushInit = 2'(FLUSH_CYCLES - 1);
    localparam logic [7:0] McTimeout = 8'(MC_TIMEOUT);

    state_e           state_q, state_d;
    logic [1:0]       flush_cnt_q, flush_cnt_d;
    logic [7:0]       mc_cnt_q, mc_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic take_branch, take_hazard, take_mc;

    assign take_mc     = x_valid_i & x_mc_start_i;
    assign take_branch = x_valid_i & x_branch_taken_i;
    assign take_hazard = x_valid_i & x_load_hazard_i;

    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        mc_cnt_d     = mc_cnt_q;
        f_stall_o    = 1'b0;
        d_stall_o    = 1'b0;
        d_kill_o     = 1'b0;
        x_stall_o    = 1'b0;
        x_kill_o     = 1'b0;
        mc_busy_o    = 1'b0;
        mc_timeout_o = 1'b0;

        if (w_stall_req_i) begin
            // Memory wait freezes everything; events are re-sampled once X advances.
            f_stall_o = 1'b1;
            d_stall_o = 1'b1;
            x_stall_o = 1'b1;
            mc_busy_o = (state_q == StMcWait);
        end else begin
            unique case (state_q)
                StRun: begin
                    if (take_mc) begin
                        f_stall_o = 1'b1;
                        d_stall_o = 1'b1;
                        x_stall_o = 1'b1;
                        state_d   = StMcWait;
                        mc_cnt_d  = 8'd1;
                    end else if (take_branch) begin
                        d_kill_o = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_d     = StFlush;
                            flush_cnt_d = FlushInit;
                        end
                    end else if (take_hazard) begin
                        f_stall_o = 1'b1;
                        d_stall_o = 1'b1;
                        x_stall_o = 1'b1;
                        x_kill_o  = 1'b1;
                        state_d   = StHaz;
                    end
                end
                StHaz: begin
                    // Stay masked while the same hazard flag is held so it is not re-triggered.
                    if (take_branch) begin
                        d_kill_o = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_d     = StFlush;
                            flush_cnt_d = FlushInit;
                        end else begin
                            state_d = StRun;
                        end
                    end else if (!take_hazard) begin
                        state_d = StRun;
                    end
                end
                StFlush: begin
                    d_kill_o = 1'b1;
                    if (flush_cnt_q <= 2'd1) begin
                        flush_cnt_d = 2'd0;
                        state_d     = StRun;
                    end else begin
                        flush_cnt_d = flush_cnt_q - 2'd1;
                    end
                end
                StMcWait: begin
                    // Busy drops in the completing cycle, together with the stalls.
                    if (x_mc_done_i) begin
                        mc_cnt_d = 8'd0;
                        state_d  = StRun;
                    end else if (mc_cnt_q >= McTimeout) begin
                        mc_timeout_o = 1'b1;
                        mc_cnt_d     = 8'd0;
                        state_d      = StRun;
                    end else begin
                        f_stall_o = 1'b1;
                        d_stall_o = 1'b1;
                        x_stall_o = 1'b1;
                        mc_busy_o = 1'b1;
                        mc_cnt_d  = mc_cnt_q + 8'd1;
                    end
                end
                default: state_d = StRun;
            endcase
        end

        if (rst_i) begin
            f_stall_o    = w_stall_req_i;
            d_stall_o    = w_stall_req_i;
            x_stall_o    = w_stall_req_i;
            d_kill_o     = 1'b0;
            x_kill_o     = 1'b0;
            mc_busy_o    = 1'b0;
            mc_timeout_o = 1'b0;
        end

        stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, d_stall_o};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StRun;
            flush_cnt_q <= 2'd0;
            mc_cnt_q    <= 8'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            mc_cnt_q    <= mc_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_rv_pipeline_ctrl.sv
// Directed bench for rv_pipeline_ctrl; expected outputs are queued per step and checked
// against the DUT mid-cycle.
module tb_rv_pipeline_ctrl;

    localparam int unsigned CntW = 16;

    // Expected output codes: {f_stall, d_stall, d_kill, x_stall, x_kill, mc_busy, mc_timeout}
    localparam logic [6:0] None = 7'b0000000;
    localparam logic [6:0] Stl  = 7'b1101000;
    localparam logic [6:0] Hzb  = 7'b1101100;
    localparam logic [6:0] Kil  = 7'b0010000;
    localparam logic [6:0] Mcb  = 7'b1101010;
    localparam logic [6:0] Tmo  = 7'b0000001;

    // Input codes: {x_valid, x_load_hazard, x_branch_taken, x_mc_start, x_mc_done, w_stall_req}
    localparam logic [5:0] Idle  = 6'b000000;
    localparam logic [5:0] Haz   = 6'b110000;
    localparam logic [5:0] Brn   = 6'b101000;
    localparam logic [5:0] BrHz  = 6'b111000;
    localparam logic [5:0] McSt  = 6'b100100;
    localparam logic [5:0] McDn  = 6'b100010;
    localparam logic [5:0] Valid = 6'b100000;
    localparam logic [5:0] Ws    = 6'b000001;
    localparam logic [5:0] HzWs  = 6'b110001;

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            x_valid_i = 1'b0;
    logic            x_load_hazard_i = 1'b0;
    logic            x_branch_taken_i = 1'b0;
    logic            x_mc_start_i = 1'b0;
    logic            x_mc_done_i = 1'b0;
    logic            w_stall_req_i = 1'b0;
    logic            f_stall_o, d_stall_o, d_kill_o, x_stall_o, x_kill_o;
    logic            mc_busy_o, mc_timeout_o;
    logic [CntW-1:0] stall_cnt_o;

    logic [6+CntW:0] exp_q[$];
    int unsigned     n_asserts = 0;
    int unsigned     n_fail = 0;
    int unsigned     exp_cnt = 0;

    always #5 clk_i = ~clk_i;

    rv_pipeline_ctrl #(
        .FLUSH_CYCLES(2),
        .MC_TIMEOUT  (8),
        .CNT_W       (CntW)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .x_valid_i       (x_valid_i),
        .x_load_hazard_i (x_load_hazard_i),
        .x_branch_taken_i(x_branch_taken_i),
        .x_mc_start_i    (x_mc_start_i),
        .x_mc_done_i     (x_mc_done_i),
        .w_stall_req_i   (w_stall_req_i),
        .f_stall_o       (f_stall_o),
        .d_stall_o       (d_stall_o),
        .d_kill_o        (d_kill_o),
        .x_stall_o       (x_stall_o),
        .x_kill_o        (x_kill_o),
        .mc_busy_o       (mc_busy_o),
        .mc_timeout_o    (mc_timeout_o),
        .stall_cnt_o     (stall_cnt_o)
    );

    task automatic drive(input logic [5:0] in);
        {x_valid_i, x_load_hazard_i, x_branch_taken_i, x_mc_start_i, x_mc_done_i,
         w_stall_req_i} = in;
    endtask

    // One cycle: drive at negedge, queue expectation, compare 2ns later (before posedge).
    task automatic step(input string tag, input logic [5:0] in, input logic [6:0] exp);
        logic [6+CntW:0] e;
        logic [6+CntW:0] obs;
        logic [CntW-1:0] ec;
        @(negedge clk_i);
        drive(in);
        ec = exp_cnt[CntW-1:0];
        exp_q.push_back({exp, ec});
        #2;
        obs = {f_stall_o, d_stall_o, d_kill_o, x_stall_o, x_kill_o, mc_busy_o, mc_timeout_o,
               stall_cnt_o};
        e = exp_q.pop_front();
        n_asserts++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed ctl=%b cnt=%0d expected ctl=%b cnt=%0d", tag,
                   obs[6+CntW:CntW], obs[CntW-1:0], e[6+CntW:CntW], e[CntW-1:0]);
        end
        if (exp[5] && !rst_i) exp_cnt++;
    endtask

    task automatic release_rst();
        @(negedge clk_i);
        drive(Idle);
        rst_i = 1'b0;
    endtask

    initial begin
        // Reset: only w_stall_req_i may show through
        step("rst_idle", Idle, None);
        step("rst_wstall", HzWs, Stl);
        release_rst();
        step("run_idle", Idle, None);

        // Load hazard held 3 cycles: one bubble only
        step("haz_c1", Haz, Hzb);
        step("haz_c2", Haz, None);
        step("haz_c3", Haz, None);
        step("haz_drop", Idle, None);
        step("haz_after", Idle, None);

        // Memory wait outranks a load hazard
        step("ws_over_haz", HzWs, Stl);
        step("ws_release", Idle, None);

        // Taken branch with hazard alongside: two kill cycles, no stall
        step("br_c1", BrHz, Kil);
        step("br_c2", Haz, Kil);
        step("br_done", Idle, None);

        // Branch honoured while in the post-bubble mask
        step("hazbr_bub", Haz, Hzb);
        step("hazbr_br", BrHz, Kil);
        step("hazbr_fl", Idle, Kil);
        step("hazbr_end", Idle, None);

        // Multi-cycle op, done on 6th cycle: 6 stall cycles, 5 busy
        step("mc_start", McSt, Stl);
        for (int i = 0; i < 5; i++) step("mc_wait", Valid, Mcb);
        step("mc_done", McDn, None);
        step("mc_after", Idle, None);

        // Multi-cycle timeout at count 8
        step("to_start", McSt, Stl);
        for (int i = 0; i < 7; i++) step("to_wait", Idle, Mcb);
        step("to_pulse", Idle, Tmo);
        step("to_after", Idle, None);

        // Done and timeout in the same cycle: done wins
        step("dt_start", McSt, Stl);
        for (int i = 0; i < 7; i++) step("dt_wait", Idle, Mcb);
        step("dt_done", McDn, None);
        step("dt_after", Idle, None);

        // Memory wait inside MC_WAIT freezes the timeout counter
        step("mcws_start", McSt, Stl);
        step("mcws_w1", Idle, Mcb);
        step("mcws_ws1", Ws, Mcb);
        step("mcws_ws2", Ws, Mcb);
        for (int i = 0; i < 6; i++) step("mcws_wait", Idle, Mcb);
        step("mcws_pulse", Idle, Tmo);
        step("mcws_after", Idle, None);

        // Memory wait during FLUSH: flush resumes with its remaining count
        step("fws_br", Brn, Kil);
        for (int i = 0; i < 4; i++) step("fws_ws", Ws, Stl);
        step("fws_resume", Idle, Kil);
        step("fws_end", Idle, None);

        // Async reset mid-MC_WAIT
        step("rmc_start", McSt, Stl);
        step("rmc_w1", Valid, Mcb);
        step("rmc_w2", Valid, Mcb);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        exp_cnt = 0;
        step("rmc_rst", McSt, None);
        release_rst();
        for (int i = 0; i < 10; i++) step("rmc_quiet", Idle, None);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
